dly_load_seq: RTL
=================

# dly_load_seq

Delay-load sequencer that drives the pipelined `ld`/`set`/`delay` control port of a group of fine-delay input lanes, one `ld` output bit per lane. It accepts lane-addressed delay writes and "apply" commands over a valid/ready handshake, validates each delay value, and pulses the per-lane `ld`. On apply it issues a single shared `set`. It keeps shadow copies of the pending and active delay of every lane for readback, and sits between the register/command interface and the delay lane array.

## Interface
Parameters:
- NUM_LANES, 8: number of delay lanes driven (1..32).
- LANE_BITS, 3: width of lane address; 2**LANE_BITS >= NUM_LANES.
- DELAY_VALUE, 0: reset delay of every lane (8-bit: [7:3] coarse, [2:0] fine); must match the lanes' own reset value.
- SETTLE_CYCLES, 2: idle cycles enforced after a `set` pulse (1..15).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_apply  in  1  1 = apply command (lane/delay ignored), 0 = delay write.
- cmd_lane  in  LANE_BITS  target lane of a write.
- cmd_delay  in  8  requested delay of a write.
- ld  out  NUM_LANES  one-hot, one-cycle load strobe to a lane's pipe register.
- delay_out  out  8  shared delay bus, valid while any `ld` bit is high.
- set  out  1  one-cycle strobe that transfers all loaded values into the active delays.
- busy  out  1  high whenever state != IDLE.
- dirty  out  NUM_LANES  lanes loaded since the last `set`.
- err_fine  out  1  sticky: a write had fine value > 4.
- err_lane  out  1  sticky: a write addressed lane >= NUM_LANES.
- rd_lane  in  LANE_BITS  readback address.
- rd_pend  out  8  registered pending (loaded) delay of rd_lane.
- rd_act  out  8  registered active (applied) delay of rd_lane.

## Operation
- FSM states: IDLE, LOAD, APPLY, SETTLE.
- IDLE: cmd_ready=1. On accept: cmd_apply=0 -> LOAD; cmd_apply=1 -> APPLY.
- Write capture: lane and the validated delay are registered on accept.
- Fine validation: if cmd_delay[2:0] > 4, the fine field is clamped to 4, coarse [7:3] is kept unchanged, and err_fine is set.
- LOAD (exactly 1 cycle):
  - Drives ld[lane]=1 and delay_out=validated value.
  - Updates pend[lane] and sets dirty[lane].
  - Then returns to IDLE.
  - If lane >= NUM_LANES: ld stays 0, pend/dirty are unchanged, err_lane is set.
- APPLY (1 cycle):
  - If dirty != 0: set=1; act[i] <= pend[i] for every dirty lane i; dirty cleared; then -> SETTLE.
  - If dirty == 0: set=0, no state change; then -> IDLE.
- SETTLE: holds for SETTLE_CYCLES cycles with cmd_ready=0, then returns to IDLE.
- Outputs outside LOAD/APPLY: ld=0, set=0, delay_out=0.
- Rewriting a lane before apply overwrites pend[lane]; the last value wins.
- Readback: rd_pend/rd_act are registered from pend[rd_lane]/act[rd_lane]. For an out-of-range rd_lane they return 0.
- Reset values:
  - state=IDLE, ld=0, set=0, delay_out=0.
  - busy=0, dirty=0, err_fine=0, err_lane=0.
  - All pend/act = DELAY_VALUE; rd_pend/rd_act = DELAY_VALUE after the first clock.
  - cmd_ready=0 while rst is high.
- Reset in the middle of LOAD/APPLY/SETTLE aborts immediately, with no further ld/set pulse.

## Timing
- Write accepted at edge N: ld/delay_out are high during cycle N+1; cmd_ready returns in cycle N+2.
- Maximum write throughput: one write every 2 cycles.
- Apply accepted at edge N (with dirty != 0):
  - set is high in cycle N+1.
  - act updates at the end of N+1.
  - cmd_ready returns in cycle N+2+SETTLE_CYCLES.
- Apply with dirty == 0: no set pulse; cmd_ready returns in cycle N+2.
- Guaranteed ordering: set never coincides with any ld, and is always at least 1 cycle after the last ld. The lane pipe register therefore holds the new value when set samples it.
- rd_pend/rd_act latency: 1 cycle from rd_lane, and 1 cycle after the pend/act update.
- cmd_ready depends only on state and rst, never on cmd_valid.

## Test plan
- Reset then readback: rst for 2 cycles with DELAY_VALUE=8'h2B -> all rd_pend/rd_act = 8'h2B, ld=0, set=0, cmd_ready=1 after rst falls.
- Write then apply:
  - Write lane 3 = 8'h5A, accepted at N -> ld=8'b0000_1000 and delay_out=8'h5A in N+1, dirty[3]=1.
  - Apply accepted at N+2 -> set in N+3, rd_act(3)=8'h5A, dirty=0, ready in N+4+SETTLE_CYCLES.
- Fine clamp: write lane 0 = 8'h17 -> delay_out=8'h14, err_fine=1 (sticky through a later valid write).
- Bad lane: NUM_LANES=6, write lane 7 -> no ld bit, dirty unchanged, err_lane=1. A following apply with dirty=0 produces no set pulse.
- Overwrite plus multi-lane: write lane1=8'h10, lane1=8'h21, lane2=8'h33, then apply:
  - One set pulse; rd_act(1)=8'h21, rd_act(2)=8'h33.
  - Back-to-back valid held high -> ld pulses spaced exactly 2 cycles apart.
- Reset mid-SETTLE and mid-LOAD: assert rst for 1 cycle -> no further ld/set, dirty=0, all act/pend = DELAY_VALUE, cmd_ready=1 on the cycle after rst.

Source files
------------

// File: rtl/dly_load_seq.sv
// Delay-load sequencer: validates lane delay writes, strobes per-lane ld,
// and issues a shared set on apply, keeping pending/active shadow copies.
module dly_load_seq #(
  parameter int          NUM_LANES     = 8,
  parameter int          LANE_BITS     = 3,
  parameter logic [7:0]  DELAY_VALUE   = 8'h00,
  parameter int          SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_apply,
  input  logic [LANE_BITS-1:0] cmd_lane,
  input  logic [7:0]           cmd_delay,
  output logic [NUM_LANES-1:0] ld,
  output logic [7:0]           delay_out,
  output logic                 set,
  output logic                 busy,
  output logic [NUM_LANES-1:0] dirty,
  output logic                 err_fine,
  output logic                 err_lane,
  input  logic [LANE_BITS-1:0] rd_lane,
  output logic [7:0]           rd_pend,
  output logic [7:0]           rd_act
);

  typedef enum logic [1:0] {
    IDLE, LOAD, APPLY, SETTLE
  } state_e;

  state_e               state_q, state_d;
  logic [LANE_BITS-1:0] lane_q, lane_d;
  logic [7:0]           dly_q, dly_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [NUM_LANES-1:0] dirty_q, dirty_d;
  logic                 err_fine_q, err_fine_d;
  logic                 err_lane_q, err_lane_d;
  logic [7:0]           pend_q [NUM_LANES];
  logic [7:0]           pend_d [NUM_LANES];
  logic [7:0]           act_q [NUM_LANES];
  logic [7:0]           act_d [NUM_LANES];
  logic [7:0]           rd_pend_q, rd_pend_d;
  logic [7:0]           rd_act_q, rd_act_d;

  logic                 accept;
  logic [NUM_LANES-1:0] lane_hit;
  logic [7:0]           vdly;

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    dly_d      = dly_q;
    cnt_d      = cnt_q;
    dirty_d    = dirty_q;
    err_fine_d = err_fine_q;
    err_lane_d = err_lane_q;
    pend_d     = pend_q;
    act_d      = act_q;
    rd_pend_d  = 8'h00;
    rd_act_d   = 8'h00;
    ld         = '0;
    set        = 1'b0;
    delay_out  = 8'h00;

    cmd_ready = (state_q == IDLE) && !rst;
    accept    = cmd_valid && cmd_ready;

    // Out-of-range lanes match no bit, so they never strobe or mark dirty
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_hit[i] = (lane_q == LANE_BITS'(i));
    end

    vdly = cmd_delay;
    if (cmd_delay[2:0] > 3'd4) begin
      vdly[2:0] = 3'd4;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_apply) begin
            state_d = APPLY;
          end else begin
            state_d = LOAD;
            lane_d  = cmd_lane;
            dly_d   = vdly;
            if (cmd_delay[2:0] > 3'd4) begin
              err_fine_d = 1'b1;
            end
          end
        end
      end
      LOAD: begin
        ld        = lane_hit;
        delay_out = dly_q;
        dirty_d   = dirty_q | lane_hit;
        for (int i = 0; i < NUM_LANES; i++) begin
          if (lane_hit[i]) begin
            pend_d[i] = dly_q;
          end
        end
        if (lane_hit == '0) begin
          err_lane_d = 1'b1;
        end
        state_d = IDLE;
      end
      APPLY: begin
        if (dirty_q != '0) begin
          set = 1'b1;
          for (int i = 0; i < NUM_LANES; i++) begin
            if (dirty_q[i]) begin
              act_d[i] = pend_q[i];
            end
          end
          dirty_d = '0;
          cnt_d   = 4'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < NUM_LANES; i++) begin
      if (rd_lane == LANE_BITS'(i)) begin
        rd_pend_d = pend_q[i];
        rd_act_d  = act_q[i];
      end
    end

    // Reset kills strobes within the same cycle it is seen
    if (rst) begin
      ld        = '0;
      set       = 1'b0;
      delay_out = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      dly_q      <= 8'h00;
      cnt_q      <= 4'd0;
      dirty_q    <= '0;
      err_fine_q <= 1'b0;
      err_lane_q <= 1'b0;
      rd_pend_q  <= DELAY_VALUE;
      rd_act_q   <= DELAY_VALUE;
      for (int i = 0; i < NUM_LANES; i++) begin
        pend_q[i] <= DELAY_VALUE;
        act_q[i]  <= DELAY_VALUE;
      end
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      dly_q      <= dly_d;
      cnt_q      <= cnt_d;
      dirty_q    <= dirty_d;
      err_fine_q <= err_fine_d;
      err_lane_q <= err_lane_d;
      rd_pend_q  <= rd_pend_d;
      rd_act_q   <= rd_act_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign dirty    = dirty_q;
  assign err_fine = err_fine_q;
  assign err_lane = err_lane_q;
  assign rd_pend  = rd_pend_q;
  assign rd_act   = rd_act_q;

endmodule
